// File: rtl/game_viewport_pkg.sv
// game_viewport_pkg: screen/game geometry shared by the viewport mapper and its counters.
package game_viewport_pkg;
  localparam int VGA_H_VISIBLE_AREA    = 640;
  localparam int VGA_V_VISIBLE_AREA    = 480;
  localparam int PACMAN_H_VISIBLE_AREA = 224;
  localparam int PACMAN_V_VISIBLE_AREA = 288;
  function automatic int cnt_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/game_viewport_scale_counter.sv
// scale_counter: replication counter plus game-coordinate counter for one axis of the viewport.
module scale_counter
  import game_viewport_pkg::*;
#(
  parameter int MAX   = 223,
  parameter int LIMIT = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           init_i,
  input  logic                           step_i,
  output logic                           active_d_o,
  output logic                           rep_zero_d_o,
  output logic [cnt_width(MAX+1)-1:0]    coord_d_o,
  output logic [cnt_width(MAX+1)-1:0]    coord_q_o
);
  localparam int CW = cnt_width(MAX + 1);
  localparam int RW = cnt_width(LIMIT);
  logic          active_q, active_d, adv, wrap, last;
  logic [RW-1:0] rep_q, rep_d;
  logic [CW-1:0] coord_q, coord_d;
  assign adv  = step_i & active_q;
  assign wrap = rep_q == RW'(LIMIT - 1);
  assign last = coord_q == CW'(MAX);
  // the final coordinate holds its value when the window closes
  always_comb begin
    active_d = init_i | (active_q & ~(adv & wrap & last));
    coord_d  = init_i ? '0 : (adv & wrap & ~last) ? coord_q + CW'(1) : coord_q;
    rep_d    = init_i ? '0 : adv ? (wrap ? '0 : rep_q + RW'(1)) : rep_q;
  end
  always_ff @(posedge clk) begin
    active_q <= rst ? 1'b0 : active_d;
    coord_q  <= rst ? '0 : coord_d;
    rep_q    <= rst ? '0 : rep_d;
  end
  assign active_d_o   = active_d;
  assign rep_zero_d_o = rep_d == '0;
  assign coord_d_o    = coord_d;
  assign coord_q_o    = coord_q;
endmodule

// File: rtl/game_viewport.sv
// game_viewport: maps VGA beam counters onto the scaled 224x288 game window.
// Defining VIEWPORT_BORDER_EN adds a registered `border` output for a 1-px ring around the window.
module game_viewport
  import game_viewport_pkg::*;
#(
  parameter int H_SCALE  = 1,
  parameter int V_SCALE  = 1,
  parameter int H_OFFSET = 208,
  parameter int V_OFFSET = 96
) (
  input  logic       vga_pix_clk,
  input  logic       rst,
  input  logic [9:0] vga_sx,
  input  logic [9:0] vga_sy,
  input  logic       vga_de,
  output logic [7:0] sx,
  output logic [8:0] sy,
  output logic       game_pix_stb,
  output logic       frame_stb,
  output logic       display_enabled
`ifdef VIEWPORT_BORDER_EN
  ,
  output logic       border
`endif
);
  if (H_SCALE < 1 || V_SCALE < 1) begin : g_scale_err
    $error("game_viewport: H_SCALE and V_SCALE must be >= 1");
  end
  if (H_OFFSET + PACMAN_H_VISIBLE_AREA * H_SCALE > VGA_H_VISIBLE_AREA) begin : g_h_err
    $error("game_viewport: window exceeds visible width");
  end
  if (V_OFFSET + PACMAN_V_VISIBLE_AREA * V_SCALE > VGA_V_VISIBLE_AREA) begin : g_v_err
    $error("game_viewport: window exceeds visible height");
  end
  logic       line_start, v_act_d, h_act_d, v_rep0_d, h_rep0_d, de_d, stb_d, fs_d;
  logic [7:0] sx_d;
  logic [8:0] sy_d;
  assign line_start = vga_sx == '0;
  scale_counter #(.MAX(PACMAN_V_VISIBLE_AREA - 1), .LIMIT(V_SCALE)) u_v (
    .clk          (vga_pix_clk),
    .rst          (rst),
    .init_i       (line_start && vga_sy == 10'(V_OFFSET)),
    .step_i       (line_start),
    .active_d_o   (v_act_d),
    .rep_zero_d_o (v_rep0_d),
    .coord_d_o    (sy_d),
    .coord_q_o    (sy)
  );
  // horizontal sees the already-updated vertical state, so a line-start init on H_OFFSET==0 works
  scale_counter #(.MAX(PACMAN_H_VISIBLE_AREA - 1), .LIMIT(H_SCALE)) u_h (
    .clk          (vga_pix_clk),
    .rst          (rst),
    .init_i       (v_act_d && vga_sx == 10'(H_OFFSET)),
    .step_i       (v_act_d),
    .active_d_o   (h_act_d),
    .rep_zero_d_o (h_rep0_d),
    .coord_d_o    (sx_d),
    .coord_q_o    (sx)
  );
  assign de_d  = h_act_d & v_act_d & vga_de;
  assign stb_d = de_d & h_rep0_d;
  assign fs_d  = stb_d & (sx_d == '0) & (sy_d == '0) & v_rep0_d;
  always_ff @(posedge vga_pix_clk) begin
    display_enabled <= rst ? 1'b0 : de_d;
    game_pix_stb    <= rst ? 1'b0 : stb_d;
    frame_stb       <= rst ? 1'b0 : fs_d;
  end
`ifdef VIEWPORT_BORDER_EN
  localparam int BL = H_OFFSET - 1;
  localparam int BR = H_OFFSET + PACMAN_H_VISIBLE_AREA * H_SCALE;
  localparam int BT = V_OFFSET - 1;
  localparam int BB = V_OFFSET + PACMAN_V_VISIBLE_AREA * V_SCALE;
  if (H_OFFSET < 1 || V_OFFSET < 1) begin : g_border_err
    $error("game_viewport: border ring needs H_OFFSET and V_OFFSET >= 1");
  end
  logic in_x, in_y, border_d;
  assign in_x     = vga_sx >= 10'(BL) && vga_sx <= 10'(BR);
  assign in_y     = vga_sy >= 10'(BT) && vga_sy <= 10'(BB);
  assign border_d = vga_de && ((in_y && (vga_sx == 10'(BL) || vga_sx == 10'(BR))) ||
                               (in_x && (vga_sy == 10'(BT) || vga_sy == 10'(BB))));
  always_ff @(posedge vga_pix_clk) border <= rst ? 1'b0 : border_d;
`endif
endmodule
